// File: rtl/piso_rr_serializer.sv
// Purpose: two-requester round-robin arbiter feeding one MSB-first PISO serial line.
// Latency: 1 clk from accept edge to data[W-1] on sout; W serial cycles per frame.
// Backpressure: ready only in IDLE or on the last frame bit; mid-frame requests wait with ready low.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   a_valid/a_data/a_ready  requester A word handshake (W-bit word)
//   b_valid/b_data/b_ready  requester B word handshake (W-bit word)
//   sout, sout_valid      serial bit (MSB first) and its qualifier; sout is 0 when not valid
//   frame_start           high on the MSB cycle of each frame
//   grant_id              owner of the frame on the line (0 = A, 1 = B)
//   busy                  frame in progress, identical to sout_valid

module piso_rr_serializer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    input  logic [W-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_data,
    output logic         b_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         frame_start,
    output logic         grant_id,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]    state;
    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic          gid_q;
    logic          last_grant;   // 0 = A, 1 = B; reset to B so A wins first contention

    logic          window;
    logic          sel_b;
    logic          take;

    // Accept window covers idle and the final bit, which lets the next frame
    // follow with no gap on the line.
    always_comb begin
        window  = (state == IDLE) || (cnt == CNT_ZERO);
        // B wins when it is the only requester, or when both request and A
        // owned the previous grant.
        sel_b   = b_valid && (!a_valid || (last_grant == 1'b0));
        a_ready = window && a_valid && !sel_b;
        b_ready = window && sel_b;
        take    = a_ready || b_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            gid_q      <= 1'b0;
            last_grant <= 1'b1;
        end else if (take) begin
            shreg      <= b_ready ? b_data : a_data;
            cnt        <= CNT_MAX;
            state      <= SHIFT;
            gid_q      <= b_ready;
            last_grant <= b_ready;
        end else if (state == SHIFT) begin
            // Zero fill means the register is already clear once the last
            // bit has been shifted past the MSB, so sout drops to 0 in IDLE.
            shreg <= {shreg[W-2:0], 1'b0};
            if (cnt == CNT_ZERO) begin
                state <= IDLE;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        sout_valid  = (state == SHIFT);
        busy        = sout_valid;
        sout        = sout_valid && shreg[W-1];
        frame_start = sout_valid && (cnt == CNT_MAX);
        grant_id    = gid_q;
    end

endmodule

// File: tb/tb_piso_rr_serializer.sv
// Purpose: self-checking bench for piso_rr_serializer against a frame-position model.
// Latency: model expects data[W-1] one cycle after the accept edge.
// Backpressure: queued words per requester are held on valid until the DUT raises ready.

module tb_piso_rr_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         a_valid = 1'b0;
    logic [W-1:0] a_data = '0;
    logic         a_ready;
    logic         b_valid = 1'b0;
    logic [W-1:0] b_data = '0;
    logic         b_ready;
    logic         sout;
    logic         sout_valid;
    logic         frame_start;
    logic         grant_id;
    logic         busy;

    piso_rr_serializer #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .frame_start (frame_start),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pending words per requester; the head is presented on the bus.
    logic [W-1:0] aq[$];
    logic [W-1:0] bq[$];

    // Model: which word is on the line and how many of its bits have gone out.
    bit           m_active = 1'b0;
    int           m_pos    = 0;
    logic [W-1:0] m_word   = '0;
    bit           m_gid    = 1'b0;
    bit           m_last   = 1'b1;

    // Per-test logs derived from the model, pinned against literals.
    bit           mlog[$];
    bit           glog[$];
    int           m_run    = 0;
    int           m_maxrun = 0;

    task automatic clear_logs();
        mlog.delete();
        glog.delete();
        m_run    = 0;
        m_maxrun = 0;
    endtask

    function automatic logic [31:0] pack_log();
        logic [31:0] v = '0;
        foreach (mlog[i]) v = {v[30:0], mlog[i]};
        return v;
    endfunction

    // Compare process: check on the falling edge, advance the model on the rising edge.
    always begin : cmp
        bit win, has, pk, e_ar, e_br, e_bit, e_fs;
        @(negedge clk);
        win   = !m_active || (m_pos == W - 1);
        has   = a_valid || b_valid;
        if (a_valid && b_valid) pk = (m_last == 1'b1) ? 1'b0 : 1'b1;
        else                    pk = b_valid;
        e_ar  = win && has && (pk == 1'b0);
        e_br  = win && has && (pk == 1'b1);
        e_bit = m_active ? m_word[W-1-m_pos] : 1'b0;
        e_fs  = m_active && (m_pos == 0);

        chk("sout",        32'(sout),        32'(e_bit));
        chk("sout_valid",  32'(sout_valid),  32'(m_active));
        chk("busy",        32'(busy),        32'(m_active));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("a_ready",     32'(a_ready),     32'(e_ar));
        chk("b_ready",     32'(b_ready),     32'(e_br));
        if (m_active) chk("grant_id", 32'(grant_id), 32'(m_gid));

        if (m_active) begin
            mlog.push_back(e_bit);
            if (e_fs) glog.push_back(m_gid);
            m_run++;
            if (m_run > m_maxrun) m_maxrun = m_run;
        end else begin
            m_run = 0;
        end

        @(posedge clk);
        if (rst) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_last   = 1'b1;
        end else if (e_ar || e_br) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_word   = e_br ? b_data : a_data;
            m_gid    = e_br;
            m_last   = e_br;
        end else if (m_active) begin
            if (m_pos == W - 1) m_active = 1'b0;
            else                m_pos++;
        end
    end

    // Requester driver: pop on an observed handshake, present the queue head.
    always begin : drv
        bit a_fire, b_fire;
        @(negedge clk);
        a_fire = a_valid && a_ready;
        b_fire = b_valid && b_ready;
        @(posedge clk);
        #1;
        if (a_fire && aq.size() != 0) void'(aq.pop_front());
        if (b_fire && bq.size() != 0) void'(bq.pop_front());
        a_valid = (aq.size() != 0);
        a_data  = a_valid ? aq[0] : '0;
        b_valid = (bq.size() != 0);
        b_data  = b_valid ? bq[0] : '0;
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called right after a falling edge; returns after all queued words are sent.
    task automatic drain(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (aq.size() == 0 && bq.size() == 0 && !a_valid && !b_valid && !m_active) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: drain timeout got busy expected idle", nm);
        end
        repeat (2) @(negedge clk);
    endtask

    // Returns just after the falling edge of the cycle carrying bit index p.
    task automatic wait_pos(input string nm, input int p);
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m_active && m_pos == p) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: wait for bit %0d timed out", nm, p);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset idle
        do_reset();
        @(negedge clk);
        clear_logs();
        repeat (5) @(negedge clk);
        chk("idle_bits", 32'(mlog.size()), 32'd0);

        // Single request from A
        do_reset();
        @(negedge clk);
        clear_logs();
        #1 aq.push_back(4'b1011);
        drain("single");
        chk("single_len",  32'(mlog.size()), 32'd4);
        chk("single_bits", pack_log(),       32'b1011);
        chk("single_nfr",  32'(glog.size()), 32'd1);
        chk("single_gid",  32'(glog[0]),     32'd0);

        // Contention straight after reset: A first, then B with no gap
        do_reset();
        @(negedge clk);
        clear_logs();
        #1;
        aq.push_back(4'b0011);
        bq.push_back(4'b1010);
        drain("contention");
        chk("cont_len",  32'(mlog.size()), 32'd8);
        chk("cont_bits", pack_log(),       32'b0011_1010);
        chk("cont_run",  32'(m_maxrun),    32'd8);
        chk("cont_g0",   32'(glog[0]),     32'd0);
        chk("cont_g1",   32'(glog[1]),     32'd1);

        // Fairness: both continuously valid, grants alternate
        do_reset();
        @(negedge clk);
        clear_logs();
        #1;
        aq.push_back(4'b1111);
        aq.push_back(4'b1111);
        bq.push_back(4'b1001);
        bq.push_back(4'b1001);
        drain("fairness");
        chk("fair_bits", pack_log(),       32'hF9F9);
        chk("fair_run",  32'(m_maxrun),    32'd16);
        chk("fair_nfr",  32'(glog.size()), 32'd4);
        chk("fair_g0",   32'(glog[0]),     32'd0);
        chk("fair_g1",   32'(glog[1]),     32'd1);
        chk("fair_g2",   32'(glog[2]),     32'd0);

        // Late arrival: B raises valid during A's bit 2
        do_reset();
        @(negedge clk);
        clear_logs();
        #1 aq.push_back(4'b1001);
        wait_pos("late", 1);
        #1 bq.push_back(4'b1100);
        drain("late");
        chk("late_bits", pack_log(),    32'b1001_1100);
        chk("late_run",  32'(m_maxrun), 32'd8);
        chk("late_g1",   32'(glog[1]),  32'd1);

        // Reset in the middle of an A frame
        do_reset();
        @(negedge clk);
        clear_logs();
        #1 aq.push_back(4'b1101);
        wait_pos("midrst", 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_len",  32'(mlog.size()), 32'd3);
        chk("midrst_bits", pack_log(),       32'b110);
        chk("midrst_vld",  32'(sout_valid),  32'd0);
        chk("midrst_sout", 32'(sout),        32'd0);
        clear_logs();
        #1;
        aq.push_back(4'b0101);
        bq.push_back(4'b0011);
        drain("midrst_after");
        chk("midrst_abits", pack_log(),   32'b0101_0011);
        chk("midrst_g0",    32'(glog[0]), 32'd0);
        chk("midrst_g1",    32'(glog[1]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/piso_rr_serializer.md
Name: piso_rr_serializer

Overview:
- Two-requester round-robin scheduler that shares a single PISO serial output.
- Each requester presents a W-bit parallel word with a valid/ready handshake.
- The granted word is loaded into an internal shift register and shifted out MSB-first, one bit per clock.
- Sits between parallel producers and a shared one-wire serial sink, replacing direct PISO instantiation where more than one source needs the line.

Parameters:
- W, 4, width of each parallel word and number of serial bits per frame (legal range W >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A has a word to send.
- a_data  input  W  requester A parallel word.
- a_ready  output  1  requester A word accepted this cycle.
- b_valid  input  1  requester B has a word to send.
- b_data  input  W  requester B parallel word.
- b_ready  output  1  requester B word accepted this cycle.
- sout  output  1  serial data bit, MSB first.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  high on the first (MSB) bit of each frame.
- grant_id  output  1  owner of the current frame (0 = A, 1 = B); meaningful while sout_valid = 1.
- busy  output  1  frame in progress (equal to sout_valid).

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high, named clk and rst.
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame in progress; bit counter cnt of width clog2(W) counts down from W-1 to 0.
- Reset values (applied on any clk edge with rst = 1, including mid-frame; the frame is discarded):
  - state = IDLE; sout, sout_valid, frame_start, grant_id, busy all = 0; shift register = 0; cnt = 0.
  - last_grant = B, so A wins the first contention after reset.
- Accept window: state == IDLE, or state == SHIFT with cnt == 0 (last bit).
- Arbitration (combinational, accept window only):
  - If exactly one valid is high, that requester is selected.
  - If both are high, the requester != last_grant is selected.
- Ready:
  - x_ready = accept window AND x_valid AND x selected.
  - At most one ready is high per cycle; ready is never high outside the accept window.
- Handshake:
  - Transfer occurs on the edge where x_valid & x_ready = 1.
  - Requesters must hold valid and data stable until ready. The block does not latch a dropped valid.
- On transfer edge:
  - shift register <= x_data; cnt <= W-1; state <= SHIFT; grant_id <= x; last_grant <= x.
- Output timing:
  - In SHIFT, sout = shift register MSB (registered).
  - First bit appears the cycle after the transfer edge, so latency is 1 clk from accept to data[W-1] on sout.
  - Each cycle the register shifts left by 1 with zero fill, and cnt decrements.
  - Bit data[W-1-k] appears on sout k+1 cycles after transfer.
  - sout_valid = busy = 1 for exactly W cycles per frame.
  - frame_start = 1 only when cnt == W-1.
- Back-to-back frames:
  - A transfer during the last-bit cycle starts the next frame with no gap.
  - sout_valid stays continuously high across consecutive frames.
- End of frame: in the last-bit cycle with no transfer, state -> IDLE, and sout = 0, sout_valid = 0 next cycle.
- Requests arriving mid-frame (cnt > 0) wait, and ready stays low.
- Fairness: with both requesters continuously valid, grants strictly alternate A, B, A, B...
- sout = 0 whenever sout_valid = 0.

Test Plan:
- Reset idle: rst = 1 for 2 cycles, then rst = 0 with no valids -> sout = sout_valid = frame_start = a_ready = b_ready = 0 throughout.
- Single request (W = 4): a_valid = 1, a_data = 4'b1011 ->
  - a_ready high 1 cycle;
  - next 4 cycles sout = 1, 0, 1, 1 with sout_valid = 1 and grant_id = 0;
  - frame_start high on the first bit only;
  - then sout_valid = 0.
- Contention: a_valid = b_valid = 1 from reset, a_data = 4'b0011, b_data = 4'b1010 ->
  - A is served first, then B, back-to-back;
  - sout = 0, 0, 1, 1, 1, 0, 1, 0 over 8 continuous sout_valid cycles;
  - b_ready coincides with A's last bit.
- Fairness: both valid held high for 3 frames (a_data = 4'b1111, b_data = 4'b1001) -> grant_id sequence 0, 1, 0 with 12 continuous sout_valid cycles.
- Late arrival: b_valid rises during A frame bit 2 (b_data = 4'b1100) -> b_ready stays 0 until A's last bit, then B frame 1, 1, 0, 0 follows with no gap.
- Reset mid-frame: rst = 1 during bit 2 of A frame 4'b1101 ->
  - next cycle sout = 0 and sout_valid = 0;
  - after release with both valid, A is granted first.
